imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the pipelined MIPS core: the writer side of instruction memory, which the core only reads. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words sequentially into the instruction memory write port and holds the core in reset until a complete, checksum-verified image is loaded. It sits between a host byte source (UART/JTAG bridge) and `inst_mem`, and drives the core's reset.

## Interface
Parameters:
- `ADDR_W`, 8, instruction memory word-address width; `DEPTH` = 2^ADDR_W words.

Ports:
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `wr_en` out 1: instruction memory write strobe, one-cycle pulse.
- `wr_addr` out ADDR_W: word address of the write.
- `wr_data` out 32: word to write.
- `cpu_reset` out 1: reset to the core; high while not successfully loaded.
- `busy` out 1: load in progress.
- `done` out 1: frame fully received.
- `len_err` out 1: sticky; the declared word count exceeded DEPTH.
- `csum_err` out 1: sticky; the checksum mismatched.
- `words_loaded` out 16: number of words written in the current or last load.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (each word MSB first), then one CSUM byte equal to the XOR of all data bytes.
- A byte is accepted on a rising edge where `in_valid & in_ready`.
- `in_ready` is a combinational function of state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE and DONE.
- States:
  - IDLE → LEN_HI on `start`.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO → DATA on accept if N≠0; LEN_LO → CSUM if N=0.
  - DATA → CSUM on acceptance of byte 4·N.
  - CSUM → DONE on accept.
  - DONE → LEN_HI on `start`.
- `start` is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- On `start`: clear `len_err`, `csum_err`, `words_loaded`, the byte and word counters and the XOR accumulator. Assert `cpu_reset`.
- `len_err` is set in LEN_LO if N > DEPTH. The load continues and `wr_addr` wraps modulo DEPTH, so later words overwrite earlier ones.
- In DATA, a 2-bit byte counter shifts bytes into a 32-bit assembly register MSB first. Every data byte is XORed into the accumulator.
- On acceptance of the 4th byte of a word: next cycle `wr_en`=1, `wr_data`=assembled word, `wr_addr`=word index mod DEPTH. The word index then increments and `words_loaded` increments.
- In CSUM, `csum_err` is set if the received byte ≠ accumulator.
- `cpu_reset` clears on entry to DONE only if `len_err`=0 and `csum_err`=0; otherwise it stays 1.
- `busy` = state ∈ {LEN_HI, LEN_LO, DATA, CSUM}. `done` = state is DONE.

## Timing
- Reset values: state IDLE, `in_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `cpu_reset` 1, `busy` 0, `done` 0, `len_err` 0, `csum_err` 0, `words_loaded` 0.
- Write latency: `wr_en` is high in the cycle after the edge that accepts a word's 4th byte, for exactly 1 cycle.
- Back-to-back bytes at 1 byte/cycle are supported. The maximum write rate is 1 word per 4 cycles.
- `in_valid` low stalls the loader indefinitely without loss of state.
- `start` in the same cycle as `in_valid` in IDLE: no byte is accepted that cycle (`in_ready` is 0); LEN_HI is entered on the next edge.
- The last data byte and CSUM can be accepted on consecutive edges. `wr_en` for the last word then coincides with the CSUM acceptance cycle.
- `cpu_reset` falls on the same edge that enters DONE.
- `reset` mid-load: the loader returns to IDLE on that edge. Writes already issued are not undone. `cpu_reset` returns to 1.

## Test plan
- Load N=2, bytes 00 02 3C 08 00 10 21 08 00 01 0C at 1 byte/cycle → writes addr0=0x3C080010 and addr1=0x21080001, `done`=1, `csum_err`=0, `cpu_reset`=0, `words_loaded`=2.
- Same frame with CSUM=0x0D → both writes occur, `csum_err`=1, `cpu_reset` stays 1; a new `start` clears `csum_err`.
- N=0, bytes 00 00 00 → no `wr_en`, DONE, `cpu_reset`=0, `words_loaded`=0.
- ADDR_W=2, N=5 → `len_err`=1 after LEN_LO; the 5th word is written to addr 0; `cpu_reset` stays 1.
- Random `in_valid` gaps during the first frame → same writes as the gap-free case; `start` pulsed during DATA is ignored.
- Assert `reset` after 6 data bytes → IDLE, `in_ready`=0, `cpu_reset`=1; a full reload then succeeds.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: loads a program image into instruction memory.
//
// Receives a framed byte stream (LEN_HI, LEN_LO, 4*N data bytes, CSUM) over
// a valid/ready handshake. It packs the data bytes MSB first into 32-bit words
// and writes them to sequential word addresses. The core is held in reset
// until a frame arrives with an in-range length and a matching XOR checksum.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle pulse that begins a load (IDLE/DONE only)
//   in_data/in_valid    byte stream from the host
//   in_ready            loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data  instruction memory write port
//   cpu_reset           core reset, low only after a clean load
//   busy, done          load in progress / frame fully received
//   len_err, csum_err   sticky error flags for the current/last load
//   words_loaded        words written in the current/last load
`timescale 1ns/1ps
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              csum_err,
    output logic [15:0]       words_loaded
);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;      // first three bytes of the word being assembled
    logic [7:0]  acc_q;      // XOR of all data bytes seen so far
    logic        accept;
    logic        start_ok;
    logic        word_end;
    logic [15:0] len_full;

    assign accept   = in_valid & in_ready;
    assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign len_full = {len_hi_q, in_data};
    assign word_end = (byte_cnt == 2'd3);
    assign busy     = (state_q == S_LEN_HI) | (state_q == S_LEN_LO) |
                      (state_q == S_DATA)   | (state_q == S_CSUM);
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LEN_HI;
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (len_full == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
                in_ready = 1'b1;
                // word_idx still holds the index of the word being finished
                if (in_valid && word_end && (words_loaded + 16'd1 == len_q))
                    state_d = S_CSUM;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_DONE;
            end
            S_DONE:   if (start) state_d = S_LEN_HI;
            default:  state_d = S_IDLE;
        endcase
    end

    // words_loaded doubles as the word index; wr_addr is its low bits, so an
    // oversized image wraps and overwrites from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            len_q        <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            acc_q        <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            cpu_reset    <= 1'b1;
            len_err      <= 1'b0;
            csum_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= 1'b0;
            if (start_ok) begin
                len_err      <= 1'b0;
                csum_err     <= 1'b0;
                words_loaded <= '0;
                byte_cnt     <= '0;
                acc_q        <= '0;
                cpu_reset    <= 1'b1;
            end
            if (accept) begin
                case (state_q)
                    S_LEN_HI: len_hi_q <= in_data;
                    S_LEN_LO: begin
                        len_q <= len_full;
                        if ({1'b0, len_full} > DEPTH) len_err <= 1'b1;
                    end
                    S_DATA: begin
                        acc_q    <= acc_q ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_q    <= {asm_q[15:0], in_data};
                        if (word_end) begin
                            wr_en        <= 1'b1;
                            wr_data      <= {asm_q, in_data};
                            wr_addr      <= words_loaded[ADDR_W-1:0];
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    S_CSUM: begin
                        if (in_data != acc_q) csum_err <= 1'b1;
                        // release the core only on a clean frame
                        cpu_reset <= len_err | (in_data != acc_q);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int AW  = 4;
    localparam int DEP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, wr_en, cpu_reset, busy, done, len_err, csum_err;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [15:0]   words_loaded;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .len_err(len_err), .csum_err(csum_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed and expected write logs
    int          got_addr[$], got_cyc[$], exp_addr[$], exp_cyc[$];
    logic [31:0] got_data[$], exp_data[$];
    logic [31:0] fw [0:63];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    endtask

    // Pulse start (optionally with a stray valid byte, which must be ignored).
    task automatic do_start(input bit with_valid);
        clear_logs();
        @(negedge clk);
        start = 1'b1; in_valid = with_valid; in_data = 8'hAA;
        #1 check("ready_at_start", in_ready, 1'b0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        #1;
        check("busy_after_start", busy, 1'b1);
        check("cpu_reset_after_start", cpu_reset, 1'b1);
        check("csum_err_cleared", csum_err, 1'b0);
        check("len_err_cleared", len_err, 1'b0);
        check("words_cleared", words_loaded, 16'd0);
    endtask

    // Drive a frame of n words from fw[] (stopping after max_bytes if >= 0).
    task automatic send_frame(input int n, input bit bad, input int gap_pct,
                              input bit mid_start, input int max_bytes);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        int idx, guard, nb;
        cs = 8'h00;
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        for (int w = 0; w < n; w++)
            for (int b = 3; b >= 0; b--) begin
                bytes.push_back(fw[w][8*b +: 8]);
                cs = cs ^ fw[w][8*b +: 8];
            end
        bytes.push_back(bad ? (cs ^ 8'h01) : cs);
        nb = (max_bytes >= 0) ? max_bytes : bytes.size();
        idx = 0; guard = 0;
        while (idx < nb && guard < 5000) begin
            @(negedge clk);
            guard++;
            start = (mid_start && idx == 6);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) in_valid = 1'b0;
            else begin in_valid = 1'b1; in_data = bytes[idx]; end
            #1;
            if (in_valid && in_ready) begin
                if (idx >= 2 && idx < 2 + 4*n && ((idx - 2) % 4) == 3) begin
                    exp_addr.push_back(((idx - 2) / 4) % DEP);
                    exp_data.push_back(fw[(idx - 2) / 4]);
                    exp_cyc.push_back(cyc + 1);
                end
                idx++;
            end
        end
        check("frame_timeout", guard < 5000, 1'b1);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic check_writes();
        check("wr_count", got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), got_addr[i], exp_addr[i]);
            check($sformatf("wr_data[%0d]", i), got_data[i], exp_data[i]);
            check($sformatf("wr_cyc[%0d]", i), got_cyc[i], exp_cyc[i]);
        end
    endtask

    task automatic check_end(input int n, input bit bad);
        bit le;
        le = (n > DEP);
        @(negedge clk);
        #1;
        check_writes();
        check("done", done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("ready_done", in_ready, 1'b0);
        check("len_err", len_err, le);
        check("csum_err", csum_err, bad);
        check("cpu_reset_end", cpu_reset, le | bad);
        check("words_loaded", words_loaded, 16'(n));
    endtask

    task automatic run_frame(input int n, input bit bad, input int gap_pct, input bit mid_start);
        do_start(1'b0);
        send_frame(n, bad, gap_pct, mid_start, -1);
        check_end(n, bad);
    endtask

    task automatic load_a();
        fw[0] = 32'h3C080010;
        fw[1] = 32'h21080001;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, '0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_csum_err", csum_err, 1'b0);
        check("rst_words", words_loaded, 16'd0);
        reset = 1'b0;

        // Reference frame, start coinciding with a stray valid byte in IDLE.
        load_a();
        do_start(1'b1);
        send_frame(2, 1'b0, 0, 1'b0, -1);
        check_end(2, 1'b0);

        // Same frame with corrupted checksum; start from DONE clears it.
        run_frame(2, 1'b1, 0, 1'b0);
        // Empty image.
        run_frame(0, 1'b0, 0, 1'b0);
        // Length boundary: DEPTH is legal, DEPTH+1 flags and wraps.
        for (int i = 0; i < 64; i++) fw[i] = $urandom;
        run_frame(DEP, 1'b0, 0, 1'b0);
        run_frame(DEP + 1, 1'b0, 0, 1'b0);
        // Gaps plus start pulsed during DATA.
        load_a();
        run_frame(2, 1'b0, 40, 1'b1);

        // Reset after 6 data bytes, then a full reload.
        do_start(1'b0);
        send_frame(2, 1'b0, 0, 1'b0, 8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ready", in_ready, 1'b0);
        check("abort_cpu_reset", cpu_reset, 1'b1);
        check_writes();
        run_frame(2, 1'b0, 0, 1'b0);

        // Randomized frames.
        for (int r = 0; r < 8; r++) begin
            int n;
            bit bad;
            n = $urandom_range(0, 20);
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 64; i++) fw[i] = $urandom;
            run_frame(n, bad, 30, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
